// File: rtl/rr_arb2_pkg.sv
// Shared types and constants for the two-input round-robin stream arbiter.
package rr_arb2_pkg;

  // IDLE arbitrates freely; LOCK_x holds the grant on x until its packet ends.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } arb_state_e;

  // Select encoding shared with the downstream mux2to1 datapath.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// Two-way payload select: i_sel = SEL_A picks i_a, SEL_B picks i_b.
module mux2to1
  import rr_arb2_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_sel,
  output logic [DATA_WIDTH-1:0] o_y
);

  assign o_y = (i_sel == SEL_B) ? i_b : i_a;

endmodule

// File: rtl/rr_stream_arb2.sv
// Two-input round-robin valid/ready arbiter with packet lock and a single
// registered output stage. o_sel tags the source of the registered beat.
module rr_stream_arb2
  import rr_arb2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit LOCK_EN    = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  input  logic                  i_a_valid,
  input  logic                  i_a_last,
  output logic                  o_a_ready,
  input  logic [DATA_WIDTH-1:0] i_b_data,
  input  logic                  i_b_valid,
  input  logic                  i_b_last,
  output logic                  o_b_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_sel,
  output logic                  o_valid,
  input  logic                  i_ready
);

  arb_state_e            state_q, state_d;
  logic                  ptr_q, ptr_d;     // round-robin priority: SEL_A / SEL_B
  logic                  grant_a, grant_b;
  logic                  sel;
  logic                  load_en;
  logic                  acc;
  logic                  acc_last;
  logic                  last_eff;
  logic [DATA_WIDTH-1:0] mux_data;

  // Grant: a locked source keeps the grant even while idle; otherwise the
  // single requester wins, and on contention the pointer decides.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state_q)
      LOCK_A: grant_a = 1'b1;
      LOCK_B: grant_b = 1'b1;
      default: begin
        if (i_a_valid && i_b_valid) begin
          grant_a = (ptr_q == SEL_A);
          grant_b = (ptr_q == SEL_B);
        end else begin
          grant_a = i_a_valid;
          grant_b = i_b_valid;
        end
      end
    endcase
  end

  assign sel      = grant_b ? SEL_B : SEL_A;
  assign load_en  = ~o_valid | i_ready;
  // Readies are forced low while reset is asserted so nothing is accepted.
  assign o_a_ready = grant_a & load_en & i_rst_n;
  assign o_b_ready = grant_b & load_en & i_rst_n;
  assign acc       = (o_a_ready & i_a_valid) | (o_b_ready & i_b_valid);
  assign acc_last  = (sel == SEL_B) ? i_b_last : i_a_last;
  // Without locking every beat closes its own packet.
  assign last_eff  = acc_last | (LOCK_EN == 1'b0);

  mux2to1 #(.DATA_WIDTH(DATA_WIDTH)) u_mux (
    .i_a   (i_a_data),
    .i_b   (i_b_data),
    .i_sel (sel),
    .o_y   (mux_data)
  );

  // Next state and pointer: only an accepted beat moves either of them.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (acc) begin
      if (last_eff) begin
        state_d = IDLE;
        ptr_d   = ~sel;
      end else begin
        state_d = (sel == SEL_B) ? LOCK_B : LOCK_A;
      end
    end
  end

  // Arbitration state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= SEL_A;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Output stage: refills whenever empty or draining; holds under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_sel   <= SEL_A;
    end else if (load_en) begin
      o_valid <= acc;
      if (acc) begin
        o_data <= mux_data;
        o_last <= acc_last;
        o_sel  <= sel;
      end
    end
  end

endmodule
